// File: rtl/stb_pkg.sv
// Shared types and default sizing for the store-buffer drain controller.
package stb_pkg;

  localparam int DEFAULT_CNT_WIDTH  = 16;
  localparam int DEFAULT_WDT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    POP    = 2'd2,
    SETTLE = 2'd3
  } stb_drain_state_e;

endpackage

// File: rtl/stb_drain_controller_if.sv
// Store buffer / dcache / LSU handshake bundle seen by the drain controller.
interface stb_drain_controller_if
  import stb_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);

  logic                 stb_empty;
  logic                 stb_wr_en;
  logic                 dcache2stb_ack;
  logic                 lsu2stb_flush_req;
  logic                 stb_rd_en;
  logic                 rd_sel;
  logic                 stb2dcache_req;
  logic                 stb2dcache_w_en;
  logic                 stb2lsu_flush_ack;
  logic [CNT_WIDTH-1:0] stb_drain_cnt;
  logic                 stb_err;

  modport master (
    input  stb_empty,
    input  stb_wr_en,
    input  dcache2stb_ack,
    input  lsu2stb_flush_req,
    output stb_rd_en,
    output rd_sel,
    output stb2dcache_req,
    output stb2dcache_w_en,
    output stb2lsu_flush_ack,
    output stb_drain_cnt,
    output stb_err
  );

  modport slave (
    output stb_empty,
    output stb_wr_en,
    output dcache2stb_ack,
    output lsu2stb_flush_req,
    input  stb_rd_en,
    input  rd_sel,
    input  stb2dcache_req,
    input  stb2dcache_w_en,
    input  stb2lsu_flush_ack,
    input  stb_drain_cnt,
    input  stb_err
  );

endinterface

// File: rtl/stb_drain_wdt.sv
// Ack watchdog: counts cycles spent waiting in REQ and raises a sticky error at the limit.
module stb_drain_wdt
  import stb_pkg::*;
#(
  parameter int WDT_CYCLES = DEFAULT_WDT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stb_drain_state_e state,
  input  logic             req_start,
  output logic             stb_err
);

  localparam int                WDT_W     = $clog2(WDT_CYCLES) + 1;
  localparam logic [WDT_W-1:0]  WDT_LIMIT = WDT_W'(WDT_CYCLES);

  logic [WDT_W-1:0] wdt_cnt;

  // Counter saturates at the limit; the controller keeps waiting, only the flag reports it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
      stb_err <= 1'b0;
    end else if (req_start) begin
      wdt_cnt <= '0;
    end else if (state == REQ && wdt_cnt != WDT_LIMIT) begin
      wdt_cnt <= wdt_cnt + 1'b1;
      if (wdt_cnt == WDT_LIMIT - 1'b1) begin
        stb_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stb_drain_controller.sv
// Drains committed stores into the dcache oldest first and acks LSU fences once empty.
// Optional ack watchdog is compiled in by defining STB_DRAIN_WDT_EN.
module stb_drain_controller
  import stb_pkg::*;
#(
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH,
  parameter int WDT_CYCLES = DEFAULT_WDT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stb_drain_controller_if.master bus
);

  stb_drain_state_e     state_q;
  logic                 rd_sel_q;
  logic                 req_q;
  logic                 flush_pend_q;
  logic                 flush_ack_q;
  logic [CNT_WIDTH-1:0] drain_cnt_q;
  logic                 flush_seen;

  if (WDT_CYCLES < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("stb_drain_controller: CNT_WIDTH and WDT_CYCLES must be positive");
  end

  // A request seen during the ack cycle is the LSU still holding its level, so it does not re-arm.
  assign flush_seen = flush_pend_q | (bus.lsu2stb_flush_req & ~flush_ack_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_sel_q     <= 1'b0;
      req_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_ack_q  <= 1'b0;
      drain_cnt_q  <= '0;
    end else begin
      flush_ack_q  <= 1'b0;
      flush_pend_q <= flush_seen;
      case (state_q)
        IDLE: begin
          if (!bus.stb_empty) begin
            state_q  <= REQ;
            rd_sel_q <= 1'b1;
            req_q    <= 1'b1;
          end else if (flush_seen) begin
            flush_ack_q  <= 1'b1;
            flush_pend_q <= 1'b0;
          end
        end
        REQ: begin
          if (bus.dcache2stb_ack) begin
            state_q  <= POP;
            rd_sel_q <= 1'b0;
            req_q    <= 1'b0;
          end
        end
        // A write in the same cycle wins in the datapath, so the pop is retried until it lands.
        POP: begin
          if (!bus.stb_wr_en) begin
            state_q     <= SETTLE;
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        SETTLE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          rd_sel_q <= 1'b0;
          req_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stb_rd_en         = (state_q == POP);
  assign bus.rd_sel            = rd_sel_q;
  assign bus.stb2dcache_req    = req_q;
  assign bus.stb2dcache_w_en   = req_q;
  assign bus.stb2lsu_flush_ack = flush_ack_q;
  assign bus.stb_drain_cnt     = drain_cnt_q;

`ifdef STB_DRAIN_WDT_EN
  logic req_start;

  assign req_start = (state_q == IDLE) && !bus.stb_empty;

  stb_drain_wdt #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state_q),
    .req_start(req_start),
    .stb_err  (bus.stb_err)
  );
`else
  assign bus.stb_err = 1'b0;
`endif

endmodule

// File: tb/tb_stb_drain_controller.sv
// Self-checking bench for stb_drain_controller: directed timing scenarios plus a randomized run
// against an occupancy/handshake reference model. The watchdog scenario runs when STB_DRAIN_WDT_EN is defined.
module tb_stb_drain_controller;

  localparam int CNT_W   = 4;
  localparam int WDT_CYC = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks  = 0;
  int errors  = 0;
  int occ     = 0;
  int load_n  = 0;
  int exp_cnt = 0;

  stb_drain_controller_if #(.CNT_WIDTH(CNT_W)) bus ();

  stb_drain_controller #(
    .CNT_WIDTH (CNT_W),
    .WDT_CYCLES(WDT_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Store buffer occupancy: writes win over pops in the same cycle; load_n preloads entries.
  assign bus.stb_empty = (occ <= 0);
  always @(posedge clk)
    occ <= occ + load_n + (bus.stb_wr_en ? 1 : 0) - ((bus.stb_rd_en && !bus.stb_wr_en) ? 1 : 0);

  function automatic logic [CNT_W+5:0] all_outs();
    return {bus.stb_rd_en, bus.rd_sel, bus.stb2dcache_req, bus.stb2dcache_w_en,
            bus.stb2lsu_flush_ack, bus.stb_err, bus.stb_drain_cnt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.stb_wr_en = 1'b0;
    bus.dcache2stb_ack = 1'b0;
    bus.lsu2stb_flush_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_cnt = 0;
    step();
  endtask

  task automatic drain_all(input int max_cycles);
    int quiet = 0;
    for (int i = 0; i < max_cycles && quiet < 3; i++) begin
      bus.dcache2stb_ack = bus.stb2dcache_req;
      step();
      if (occ == 0 && !bus.stb2dcache_req && !bus.stb_rd_en) quiet++;
      else quiet = 0;
    end
    bus.dcache2stb_ack = 1'b0;
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("[TB] FAIL drain_timeout: occupancy %0d, required 0 within %0d cycles", occ, max_cycles);
    end
  endtask

  task automatic test_reset();
    bus.stb_wr_en = 1'b0;
    bus.dcache2stb_ack = 1'b0;
    bus.lsu2stb_flush_req = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_during: outputs %h, required 0", all_outs());
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_after: outputs %h, required 0", all_outs());
    end
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    load_n = 1;
    step();
    load_n = 0;
    checks++;
    if (bus.stb2dcache_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_idle: req %b, required 0", bus.stb2dcache_req);
    end
    step();
    checks++;
    if ({bus.stb2dcache_req, bus.rd_sel, bus.stb2dcache_w_en, bus.stb_rd_en} !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL basic_req: req/rd_sel/w_en/rd_en %b%b%b%b, required 1110",
               bus.stb2dcache_req, bus.rd_sel, bus.stb2dcache_w_en, bus.stb_rd_en);
    end
    bus.dcache2stb_ack = 1'b1;
    step();
    bus.dcache2stb_ack = 1'b0;
    checks++;
    if ({bus.stb2dcache_req, bus.rd_sel, bus.stb_rd_en} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL basic_pop: req/rd_sel/rd_en %b%b%b, required 001",
               bus.stb2dcache_req, bus.rd_sel, bus.stb_rd_en);
    end
    step();
    exp_cnt++;
    checks++;
    if (bus.stb_rd_en !== 1'b0 || bus.stb_drain_cnt !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL basic_settle: rd_en %b cnt %0d, required rd_en 0 cnt %0d",
               bus.stb_rd_en, bus.stb_drain_cnt, CNT_W'(exp_cnt));
    end
    step();
    step();
    checks++;
    if ({bus.stb_rd_en, bus.rd_sel, bus.stb2dcache_req, bus.stb2lsu_flush_ack} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL basic_back_idle: strobes %b%b%b%b, required 0000",
               bus.stb_rd_en, bus.rd_sel, bus.stb2dcache_req, bus.stb2lsu_flush_ack);
    end
  endtask

  task automatic test_delayed_ack();
    int req_cycles = 0;
    int pop_cycles = 0;
    int rdsel_bad  = 0;
    load_n = 1;
    step();
    load_n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.stb2dcache_req) begin
        req_cycles++;
        if (!bus.rd_sel) rdsel_bad++;
      end
      if (bus.stb_rd_en) pop_cycles++;
      bus.dcache2stb_ack = bus.stb2dcache_req && (req_cycles == 11);
    end
    bus.dcache2stb_ack = 1'b0;
    exp_cnt++;
    checks++;
    if (req_cycles != 11 || rdsel_bad != 0) begin
      errors++;
      $display("[TB] FAIL delayed_req_len: req cycles %0d (rd_sel low %0d), required 11 (0)", req_cycles, rdsel_bad);
    end
    checks++;
    if (pop_cycles != 1) begin
      errors++;
      $display("[TB] FAIL delayed_single_pop: rd_en cycles %0d, required 1", pop_cycles);
    end
    checks++;
    if (bus.stb_drain_cnt !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL delayed_cnt: cnt %0d, required %0d", bus.stb_drain_cnt, CNT_W'(exp_cnt));
    end
  endtask

  task automatic test_wr_conflict();
    int rd_cycles = 0;
    load_n = 1;
    step();
    load_n = 0;
    step();
    bus.dcache2stb_ack = 1'b1;
    step();
    bus.dcache2stb_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.stb_wr_en = (i < 3);
      if (bus.stb_rd_en) rd_cycles++;
      step();
    end
    bus.stb_wr_en = 1'b0;
    exp_cnt++;
    checks++;
    if (rd_cycles != 4) begin
      errors++;
      $display("[TB] FAIL conflict_hold: rd_en cycles %0d, required 4", rd_cycles);
    end
    checks++;
    if (bus.stb_drain_cnt !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL conflict_cnt: cnt %0d, required %0d", bus.stb_drain_cnt, CNT_W'(exp_cnt));
    end
    drain_all(100);
    exp_cnt += 3;
    checks++;
    if (bus.stb_drain_cnt !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL conflict_drain_cnt: cnt %0d, required %0d", bus.stb_drain_cnt, CNT_W'(exp_cnt));
    end
  endtask

  task automatic test_flush_idle();
    bus.lsu2stb_flush_req = 1'b1;
    step();
    bus.lsu2stb_flush_req = 1'b0;
    checks++;
    if (bus.stb2lsu_flush_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_idle_ack: ack %b, required 1", bus.stb2lsu_flush_ack);
    end
    step();
    checks++;
    if (bus.stb2lsu_flush_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_idle_pulse: ack %b, required 0", bus.stb2lsu_flush_ack);
    end
  endtask

  task automatic test_flush_queued();
    int acks = 0;
    int ack_cycle = -1;
    int last_pop = -1;
    logic empty_at_ack = 1'b0;
    logic [CNT_W-1:0] cnt_at_ack = '0;
    load_n = 3;
    step();
    load_n = 0;
    bus.lsu2stb_flush_req = 1'b1;
    step();
    bus.lsu2stb_flush_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus.dcache2stb_ack = bus.stb2dcache_req;
      if (bus.stb_rd_en) last_pop = i;
      if (bus.stb2lsu_flush_ack) begin
        acks++;
        ack_cycle = i;
        empty_at_ack = bus.stb_empty;
        cnt_at_ack = bus.stb_drain_cnt;
      end
      step();
    end
    bus.dcache2stb_ack = 1'b0;
    exp_cnt += 3;
    checks++;
    if (acks != 1) begin
      errors++;
      $display("[TB] FAIL flush_q_count: flush acks %0d, required 1", acks);
    end
    checks++;
    if (ack_cycle <= last_pop + 1 || empty_at_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_q_order: ack at %0d (empty %b) last pop %0d, required after settle with empty 1",
               ack_cycle, empty_at_ack, last_pop);
    end
    checks++;
    if (cnt_at_ack !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL flush_q_cnt: cnt at ack %0d, required %0d", cnt_at_ack, CNT_W'(exp_cnt));
    end
  endtask

  task automatic test_reset_mid_req();
    load_n = 1;
    step();
    load_n = 0;
    step();
    checks++;
    if (bus.stb2dcache_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre_req: req %b, required 1", bus.stb2dcache_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("[TB] FAIL rst_async: outputs %h, required 0", all_outs());
    end
    step();
    step();
    rst_n = 1'b1;
    exp_cnt = 0;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("[TB] FAIL rst_release: outputs %h, required 0", all_outs());
    end
    step();
    checks++;
    if (bus.stb2dcache_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_restart: req %b, required 1", bus.stb2dcache_req);
    end
    drain_all(50);
    exp_cnt++;
    checks++;
    if (bus.stb_drain_cnt !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL rst_drain_cnt: cnt %0d, required %0d", bus.stb_drain_cnt, CNT_W'(exp_cnt));
    end
  endtask

  task automatic test_random();
    int pops = 0;
    int writes = 0;
    int acked = 0;
    int target = 0;
    int wait_cnt = 0;
    bit fpend = 0;
    bit quiesce;
    logic prev_empty = 1'b1;
    logic cur_empty, r_req, r_ack, r_rd_en, r_wr, r_flush;
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      checks++;
      if (bus.stb2dcache_w_en !== bus.stb2dcache_req || bus.rd_sel !== bus.stb2dcache_req) begin
        errors++;
        $display("[TB] FAIL rnd_req_qual: req %b w_en %b rd_sel %b, required all equal",
                 bus.stb2dcache_req, bus.stb2dcache_w_en, bus.rd_sel);
      end
      checks++;
      if (bus.stb_rd_en && (acked != 1 || bus.stb2dcache_req)) begin
        errors++;
        $display("[TB] FAIL rnd_pop_legal: rd_en with %0d unpopped acks (req %b), required 1 and req 0",
                 acked, bus.stb2dcache_req);
      end
      if (bus.stb2lsu_flush_ack) begin
        checks++;
        if (!fpend || !prev_empty) begin
          errors++;
          $display("[TB] FAIL rnd_flush_ack: pending %0d prev empty %b, required 1 and 1", fpend, prev_empty);
        end
        fpend = 0;
      end
      quiesce = (i >= 800);
      bus.stb_wr_en = !quiesce && ($urandom_range(0, 99) < 10);
      bus.lsu2stb_flush_req = !quiesce && !bus.stb2lsu_flush_ack && ($urandom_range(0, 39) == 0);
      if (bus.stb2dcache_req) begin
        if (wait_cnt >= target) begin
          bus.dcache2stb_ack = 1'b1;
          target = $urandom_range(0, 5);
          wait_cnt = 0;
        end else begin
          bus.dcache2stb_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.dcache2stb_ack = ($urandom_range(0, 15) == 0);
        wait_cnt = 0;
      end
      r_req = bus.stb2dcache_req;
      r_ack = bus.dcache2stb_ack;
      r_rd_en = bus.stb_rd_en;
      r_wr = bus.stb_wr_en;
      r_flush = bus.lsu2stb_flush_req;
      cur_empty = bus.stb_empty;
      step();
      if (r_req && r_ack) acked++;
      if (r_rd_en && !r_wr) begin
        pops++;
        acked--;
      end
      if (r_wr) writes++;
      if (r_flush) fpend = 1;
      prev_empty = cur_empty;
      checks++;
      if (bus.stb_drain_cnt !== CNT_W'(pops)) begin
        errors++;
        $display("[TB] FAIL rnd_cnt: cnt %0d, required %0d", bus.stb_drain_cnt, CNT_W'(pops));
      end
      checks++;
      if (acked < 0 || acked > 1) begin
        errors++;
        $display("[TB] FAIL rnd_ack_balance: unpopped acks %0d, required 0..1", acked);
      end
`ifndef STB_DRAIN_WDT_EN
      checks++;
      if (bus.stb_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rnd_err_tied: stb_err %b, required 0", bus.stb_err);
      end
`endif
    end
    bus.stb_wr_en = 1'b0;
    bus.lsu2stb_flush_req = 1'b0;
    bus.dcache2stb_ack = 1'b0;
    checks++;
    if (pops != writes || occ != 0) begin
      errors++;
      $display("[TB] FAIL rnd_all_drained: pops %0d occupancy %0d, required %0d and 0", pops, occ, writes);
    end
    checks++;
    if (fpend || acked != 0) begin
      errors++;
      $display("[TB] FAIL rnd_end_state: flush pending %0d unpopped acks %0d, required 0 and 0", fpend, acked);
    end
    $display("[TB] random run: %0d stores drained", pops);
  endtask

`ifdef STB_DRAIN_WDT_EN
  task automatic test_wdt();
    int req_cycles = 0;
    do_reset();
    load_n = 1;
    step();
    load_n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.stb2dcache_req) req_cycles++;
      if (req_cycles == 8) begin
        checks++;
        if (bus.stb_err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL wdt_early: stb_err %b in REQ cycle 8, required 0", bus.stb_err);
        end
      end
      if (req_cycles == 9) begin
        checks++;
        if (bus.stb_err !== 1'b1) begin
          errors++;
          $display("[TB] FAIL wdt_fire: stb_err %b in REQ cycle 9, required 1", bus.stb_err);
        end
      end
    end
    checks++;
    if (req_cycles != 12) begin
      errors++;
      $display("[TB] FAIL wdt_waiting: REQ cycles %0d, required 12", req_cycles);
    end
    drain_all(50);
    checks++;
    if (bus.stb_err !== 1'b1 || bus.stb_drain_cnt !== CNT_W'(1)) begin
      errors++;
      $display("[TB] FAIL wdt_sticky: stb_err %b cnt %0d, required 1 and 1", bus.stb_err, bus.stb_drain_cnt);
    end
  endtask
`endif

  initial begin
    bus.stb_wr_en = 1'b0;
    bus.dcache2stb_ack = 1'b0;
    bus.lsu2stb_flush_req = 1'b0;
    test_reset();
    test_basic();
    test_delayed_ack();
    test_wr_conflict();
    test_flush_idle();
    test_flush_queued();
    test_reset_mid_req();
    test_random();
`ifdef STB_DRAIN_WDT_EN
    test_wdt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stb_drain_controller.md
# stb_drain_controller

Drains committed stores from `store_buffer_datapath` into the data cache, one entry at a time, oldest first. It sits directly downstream of the store buffer datapath. It drives the buffer's `rd_sel`/`stb_rd_en` and runs the request/acknowledge handshake with the dcache. It also serves LSU fence/flush requests by signalling when the buffer has fully drained, and keeps a running count of retired stores.

## Interface
- `CNT_WIDTH`, 16: width of the drained-store counter.
- `WDT_CYCLES`, 256: ack-timeout threshold in cycles; used only when the watchdog is compiled in.
- `clk` in 1: single clock domain, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `stb_empty` in 1: store buffer datapath has no valid entries.
- `stb_wr_en` in 1: LSU write into the store buffer this cycle; the datapath gives writes priority over pops.
- `dcache2stb_ack` in 1: one-cycle pulse; dcache accepted the presented store.
- `lsu2stb_flush_req` in 1: level; LSU requests a full drain (fence).
- `stb_rd_en` out 1: pop the oldest entry (advance the read index, clear its valid bit).
- `rd_sel` out 1: present the oldest entry on `stb2dcache_*`.
- `stb2dcache_req` out 1: store request valid to dcache.
- `stb2dcache_w_en` out 1: write qualifier to dcache; always equal to `stb2dcache_req`.
- `stb2lsu_flush_ack` out 1: one-cycle pulse; flush complete.
- `stb_drain_cnt` out CNT_WIDTH: number of stores retired since reset; wraps modulo 2^CNT_WIDTH.
- `stb_err` out 1: sticky watchdog timeout flag.

## Operation
- FSM states:
  - IDLE: all strobes low. If `!stb_empty`, go to REQ.
  - REQ: `rd_sel=1`, `stb2dcache_req=1`, `stb2dcache_w_en=1`. Hold until `dcache2stb_ack`, then go to POP. `rd_sel` stays high throughout REQ so the address, data and byte selects remain stable.
  - POP: `stb_rd_en=1`, `rd_sel=0`, `req=0`. The pop counts as taken on the first cycle in POP with `stb_wr_en==0`; `stb_rd_en` stays high across any cycles with `stb_wr_en==1`. On a taken pop, increment `stb_drain_cnt` and go to SETTLE.
  - SETTLE: one cycle with all strobes low, so the datapath's valid/empty state updates. Then go to IDLE.
- Exactly one `stb_rd_en` pulse is taken per acknowledged store. The controller never pops without a prior ack.
- `dcache2stb_ack` outside REQ is ignored.
- Flush:
  - A cycle with `lsu2stb_flush_req=1` sets the internal `flush_pend`.
  - When `flush_pend && state==IDLE && stb_empty`, pulse `stb2lsu_flush_ack` for one cycle and clear `flush_pend`.
  - A flush request while the buffer is already empty and the FSM is in IDLE is acked in the next cycle.
  - Stores written during a flush are also drained before the ack.
- Reset, asynchronous and possibly mid-transaction:
  - FSM returns to IDLE; `flush_pend=0`; counter=0; `stb_err=0`.
  - All outputs are 0 during and immediately after reset.

## Timing
- IDLE to REQ: 1 cycle after `stb_empty` falls.
- Minimum drain with an immediate ack and no write conflict is 4 cycles: IDLE, REQ, POP, SETTLE. Throughput is one store per 4 cycles.
- Ack may arrive in the first REQ cycle. There is no upper bound on ack latency.
- `stb2dcache_*` data is combinational from the datapath when `rd_sel=1`. Outputs of this block are registered (Moore), except `stb_rd_en` hold, which is state-decoded.
- Buffer full has no special handling; drain proceeds normally.

## Configuration
- `STB_DRAIN_WDT_EN` defined:
  - A counter of width `$clog2(WDT_CYCLES)+1` runs while in REQ and clears on entering REQ.
  - When it reaches `WDT_CYCLES`, set `stb_err`, which is sticky until reset.
  - The FSM keeps waiting for the ack; no abort.
- Not defined: `stb_err` is tied to 0 and no counter is instantiated.

## Structure
- `stb_pkg`: `stb_drain_state_e` enum (IDLE, REQ, POP, SETTLE) and the default `CNT_WIDTH`/`WDT_CYCLES` localparams.
- One sub-module, `stb_drain_wdt`: the timeout counter plus sticky flag, instantiated only under `STB_DRAIN_WDT_EN`.

## Test plan
- Reset, then `stb_empty` falls with an ack in the first REQ cycle -> REQ at cycle 1, `stb_rd_en` for exactly 1 cycle at cycle 2, `stb_drain_cnt`=1.
- Ack delayed 10 cycles -> `req`/`rd_sel` high for 11 cycles, then a single pop.
- `stb_wr_en` high for 3 cycles starting at the POP cycle -> `stb_rd_en` held 4 cycles, counter increments once.
- Flush with 3 entries queued -> `stb2lsu_flush_ack` pulses once, only after the 3rd SETTLE with `stb_empty=1`; `stb_drain_cnt`=3.
- `rst_n` asserted mid-REQ -> all outputs 0 immediately; after release with `stb_empty=0`, draining restarts from IDLE.
- With `STB_DRAIN_WDT_EN` and `WDT_CYCLES`=8, no ack -> `stb_err` rises after 8 REQ cycles and stays high after a later ack.
